// File: rtl/mmio_io_hub.sv
// mmio_io_hub: five-word register window holding a free-running LFSR,
// debounced buttons with a press-event FIFO, per-LED on/off/blink control
// and a score register. rdata is combinational and is muxed over RAM data
// by the top level whenever hit is high.
//
// Bus handshake: wren and rden are single-cycle strobes qualified by hit.
// A store takes effect at the rising clock edge of the strobe cycle. rdata
// is valid in the same cycle as the address. A load at offset +2 pops the
// FIFO at that edge. When both strobes are high, the store is performed and
// the pop is suppressed.
module mmio_io_hub #(
    parameter logic [11:0] BASE_ADDR       = 12'd5,
    parameter int          NUM_BTN         = 4,
    parameter int          NUM_LED         = 4,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          BLINK_HALF      = 12500000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [31:0] LFSR_SEED       = 32'hACE10001
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               wren,
    input  logic               rden,
    output logic [31:0]        rdata,
    output logic               hit,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_LED-1:0] led,
    output logic [7:0]         score,
    output logic               evt_pending
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = 2 * NUM_LED;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0]   LFSR_MASK  = 32'h80200003;

    localparam logic [11:0] OFF_RAND   = 12'd0;
    localparam logic [11:0] OFF_LED    = 12'd1;
    localparam logic [11:0] OFF_EVENT  = 12'd2;
    localparam logic [11:0] OFF_STATUS = 12'd3;
    localparam logic [11:0] OFF_SCORE  = 12'd4;

    // State
    logic [31:0]        lfsr_q, lfsr_d;
    logic [LW-1:0]      led_ctrl_q, led_ctrl_d;
    logic [7:0]         score_q, score_d;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [DW-1:0]      db_cnt_q [NUM_BTN];
    logic [DW-1:0]      db_cnt_d [NUM_BTN];
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    // Decode and event-path intermediates
    logic [11:0]        off;
    logic               wr_rand, wr_led, wr_status, wr_score, pop_req;
    logic               flush, ovf_clr;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] sel_onehot;
    logic [7:0]         sel_idx;
    logic               pend_any, fifo_full, fifo_empty;
    logic               do_push, do_pop, drop;

    // Window decode and per-register strobes
    always_comb begin
        off       = addr - BASE_ADDR;
        hit       = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 13'd4));
        wr_rand   = wren && hit && (off == OFF_RAND);
        wr_led    = wren && hit && (off == OFF_LED);
        wr_status = wren && hit && (off == OFF_STATUS);
        wr_score  = wren && hit && (off == OFF_SCORE);
        pop_req   = rden && !wren && hit && (off == OFF_EVENT);
        flush     = wr_status && wdata[0];
        ovf_clr   = wr_status && wdata[31];
    end

    // LFSR: load on write (zero reloads the seed), otherwise one Galois step
    always_comb begin
        if (wr_rand) begin
            lfsr_d = (wdata == 32'd0) ? LFSR_SEED : wdata;
        end else begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
        end
    end

    // Simple writable registers: LED control and score
    always_comb begin
        led_ctrl_d = wr_led   ? wdata[LW-1:0] : led_ctrl_q;
        score_d    = wr_score ? wdata[7:0]    : score_q;
    end

    // Debounce: a level flips after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            rise[i]     = 1'b0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                    rise[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Arbiter and event FIFO: lowest pending index is pushed or dropped each cycle
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx       = 8'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        pend_any   = |pending_q;
        fifo_full  = (count_q == FIFO_FULL);
        fifo_empty = (count_q == '0);
        do_pop     = pop_req && !fifo_empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        do_push    = pend_any && (!fifo_full || do_pop) && !flush;
        drop       = pend_any && fifo_full && !do_pop && !flush;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = sel_idx;
        end
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // New rising edges survive a flush; everything older is discarded.
        pending_d  = (pending_q & ~sel_onehot) | rise;
        overflow_d = (overflow_q & ~ovf_clr) | drop;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pending_d = rise;
        end
    end

    // Blink timebase: phase toggles each time the counter wraps
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end
    end

    // Combinational read mux; unused bits read as zero
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_RAND:   rdata = lfsr_q;
                OFF_LED:    rdata[LW-1:0] = led_ctrl_q;
                OFF_EVENT: begin
                    if (!fifo_empty) begin
                        rdata[31]  = 1'b1;
                        rdata[7:0] = mem_q[rd_ptr_q];
                    end
                end
                OFF_STATUS: begin
                    rdata[31]          = overflow_q;
                    rdata[16 +: CW]    = count_q;
                    rdata[NUM_BTN-1:0] = level_q;
                end
                OFF_SCORE:  rdata[7:0] = score_q;
                default:    rdata = '0;
            endcase
        end
    end

    // LED drive from the 2-bit mode of each channel
    always_comb begin
        for (int i = 0; i < NUM_LED; i++) begin
            case (led_ctrl_q[2*i +: 2])
                2'b00:   led[i] = 1'b0;
                2'b01:   led[i] = 1'b1;
                2'b10:   led[i] = phase_q;
                default: led[i] = ~phase_q;
            endcase
        end
        score       = score_q;
        evt_pending = !fifo_empty;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q      <= LFSR_SEED;
            led_ctrl_q  <= '0;
            score_q     <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            pending_q   <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            led_ctrl_q  <= led_ctrl_d;
            score_q     <= score_d;
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            pending_q   <= pending_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed plus randomized checks of mmio_io_hub against an
// event-level reference model (press masks -> ordered index queue, cycle
// counts -> LFSR value and blink phase).
module tb_mmio_io_hub;

    localparam logic [11:0] BASE  = 12'd5;
    localparam int          NBTN  = 4;
    localparam int          NLED  = 4;
    localparam int          DEPTH = 2;
    localparam int          HALF  = 4;
    localparam logic [31:0] SEED  = 32'hACE10001;

    // ---------------- clock / reset ----------------
    logic            clock = 1'b0;
    logic            reset;
    logic [11:0]     addr;
    logic [31:0]     wdata;
    logic            wren;
    logic            rden;
    logic [31:0]     rdata;
    logic            hit;
    logic [NBTN-1:0] btn_raw;
    logic [NLED-1:0] led;
    logic [7:0]      score;
    logic            evt_pending;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    mmio_io_hub #(
        .BASE_ADDR(BASE), .NUM_BTN(NBTN), .NUM_LED(NLED),
        .DEBOUNCE_CYCLES(4), .BLINK_HALF(HALF), .FIFO_DEPTH(DEPTH),
        .LFSR_SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
        .wren(wren), .rden(rden), .rdata(rdata), .hit(hit),
        .btn_raw(btn_raw), .led(led), .score(score),
        .evt_pending(evt_pending)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic        exp_ovf;
    logic [3:0]  exp_levels;
    logic [31:0] lfsr_base;
    int          lfsr_cyc;
    int          rst_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sequence defined by the feedback polynomial x^32+x^22+x^2+x+1,
    // shifting toward bit 0 with the x^32 term re-entering at the taps.
    function automatic logic [31:0] lfsr_after(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = v;
        for (int k = 0; k < n; k++) begin
            s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_lfsr();
        return lfsr_after(lfsr_base, cyc - lfsr_cyc);
    endfunction

    function automatic logic exp_phase();
        return logic'(((cyc - rst_cyc) / HALF) % 2);
    endfunction

    function automatic logic [31:0] exp_status();
        return {exp_ovf, 7'b0, 8'(exp_q.size()), 8'b0, 4'b0, exp_levels};
    endfunction

    function automatic logic [31:0] exp_event();
        return (exp_q.size() != 0) ? {1'b1, 23'b0, exp_q[0]} : 32'd0;
    endfunction

    // Rising presses are queued lowest index first; a full queue drops them.
    task automatic model_press(input logic [3:0] mask);
        for (int i = 0; i < NBTN; i++) begin
            if (mask[i]) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
                else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf    = 1'b0;
        exp_levels = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        addr = a; wdata = d; wren = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] v);
        addr = a; rden = 1'b1;
        #1 v = rdata;
        tick();
        rden = 1'b0;
    endtask

    task automatic bus_peek(input logic [11:0] a, output logic [31:0] v);
        addr = a;
        #1 v = rdata;
    endtask

    task automatic release_reset();
        reset     = 1'b1;
        lfsr_base = SEED;
        lfsr_cyc  = cyc;
        rst_cyc   = cyc;
    endtask

    // Hold a button mask long enough to debounce and arbitrate, then release.
    task automatic press(input logic [3:0] mask, input string tag);
        logic [31:0] v;
        btn_raw = mask;
        repeat (14) tick();
        model_press(mask);
        exp_levels = mask;
        bus_read(BASE + 12'd3, v);
        check({tag, "_status_held"}, v, exp_status());
        btn_raw = '0;
        repeat (12) tick();
        exp_levels = '0;
    endtask

    task automatic read_event(input string tag);
        logic [31:0] v, e;
        e = exp_event();
        bus_read(BASE + 12'd2, v);
        check(tag, v, e);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    // ---------------- directed + randomized stimulus ----------------
    initial begin
        logic [31:0] v, e, d;
        logic ph;
        reset = 1'b0; addr = '0; wdata = '0; wren = 1'b0; rden = 1'b0; btn_raw = '0;
        model_reset();
        lfsr_base = SEED; lfsr_cyc = 0; rst_cyc = 0;
        repeat (3) tick();
        check("rst_led", 32'(led), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_pending", 32'(evt_pending), 32'd0);

        // 1. LFSR seed, one step, and zero-write reseed
        release_reset();
        bus_read(BASE, v);
        check("rand_first", v, SEED);
        e = exp_lfsr();
        bus_read(BASE, v);
        check("rand_second", v, e);
        bus_write(BASE, 32'd0);
        lfsr_base = SEED; lfsr_cyc = cyc;
        bus_read(BASE, v);
        check("rand_reseed", v, SEED);

        // window decode edges
        addr = BASE - 12'd1; #1 check("hit_below", 32'(hit), 32'd0);
        addr = BASE;         #1 check("hit_first", 32'(hit), 32'd1);
        addr = BASE + 12'd4; #1 check("hit_last", 32'(hit), 32'd1);
        addr = BASE + 12'd5; #1 check("hit_above", 32'(hit), 32'd0);
        tick();

        // 2. short pulse rejected, long press accepted
        btn_raw = 4'b0100;
        repeat (3) tick();
        btn_raw = '0;
        repeat (10) tick();
        check("glitch_pending", 32'(evt_pending), 32'd0);
        bus_read(BASE + 12'd3, v);
        check("glitch_status", v, exp_status());
        press(4'b0100, "btn2");
        check("btn2_levels_seen", 32'(exp_levels), 32'd0);
        read_event("btn2_event");
        read_event("btn2_empty");

        // 3. simultaneous presses: index order, then store+load together
        press(4'b1010, "btn31");
        bus_read(BASE + 12'd3, v);
        check("btn31_count", v, exp_status());
        addr = BASE + 12'd2; wdata = $urandom; wren = 1'b1; rden = 1'b1;
        tick();
        wren = 1'b0; rden = 1'b0;
        bus_read(BASE + 12'd3, v);
        check("wr_rd_no_pop", v, exp_status());
        read_event("btn31_first");
        read_event("btn31_second");
        read_event("pop_empty");

        // 4. overflow on a full FIFO, overflow clear, flush
        press(4'b0001, "ov0");
        press(4'b0010, "ov1");
        press(4'b0100, "ov2");
        bus_read(BASE + 12'd3, v);
        check("ov_status", v, exp_status());
        bus_write(BASE + 12'd3, 32'h80000000);
        exp_ovf = 1'b0;
        bus_read(BASE + 12'd3, v);
        check("ov_cleared", v, exp_status());
        read_event("ov_head0");
        bus_peek(BASE + 12'd2, v);
        check("ov_head1", v, exp_event());
        bus_write(BASE + 12'd3, 32'd1);
        exp_q.delete();
        bus_read(BASE + 12'd3, v);
        check("flushed", v, exp_status());
        check("flushed_pending", 32'(evt_pending), 32'd0);

        // 5. LED modes: off, on, blink, blink inverted
        check("led_off", 32'(led), 32'd0);
        bus_write(BASE + 12'd1, 32'h000000E4);
        bus_read(BASE + 12'd1, v);
        check("led_ctrl_rd", v, 32'h000000E4);
        for (int k = 0; k < 12; k++) begin
            ph = exp_phase();
            check("led_blink", 32'(led), 32'({~ph, ph, 1'b1, 1'b0}));
            tick();
        end

        // randomized presses, glitches, reads, clears and LFSR loads
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                btn_raw = 4'($urandom_range(1, 15));
                repeat ($urandom_range(1, 3)) tick();
                btn_raw = '0;
                repeat (8) tick();
            end
            press(4'($urandom_range(1, 15)), "rnd");
            bus_read(BASE + 12'd3, v);
            check("rnd_status", v, exp_status());
            check("rnd_pending", 32'(evt_pending), 32'(exp_q.size() != 0));
            repeat ($urandom_range(0, 3)) read_event("rnd_event");
            case ($urandom_range(0, 5))
                0: begin bus_write(BASE + 12'd3, 32'd1); exp_q.delete(); end
                1: begin bus_write(BASE + 12'd3, 32'h80000000); exp_ovf = 1'b0; end
                2: begin
                    d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    bus_write(BASE, d);
                    lfsr_base = (d == 32'd0) ? SEED : d; lfsr_cyc = cyc;
                end
                default: begin
                    d = $urandom;
                    bus_write(BASE + 12'd4 + 12'd1, d);
                end
            endcase
            repeat ($urandom_range(0, 5)) tick();
            e = exp_lfsr();
            bus_read(BASE, v);
            check("rnd_rand", v, e);
        end

        // 6. score write, outside-window write ignored, async reset
        bus_write(BASE + 12'd4, 32'd27);
        check("score_out", 32'(score), 32'd27);
        bus_write(BASE + 12'd5, 32'd99);
        bus_read(BASE + 12'd4, v);
        check("score_rd", v, 32'd27);
        press(4'b1000, "pre_rst");
        check("pre_rst_pending", 32'(evt_pending), 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_score_now", 32'(score), 32'd0);
        check("rst_pending_now", 32'(evt_pending), 32'd0);
        check("rst_led_now", 32'(led), 32'd0);
        tick();
        release_reset();
        bus_read(BASE + 12'd3, v);
        check("post_rst_status", v, exp_status());
        e = exp_lfsr();
        bus_read(BASE, v);
        check("post_rst_rand", v, e);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
